// File: rtl/json_feedback_receiver.sv
`default_nettype none
// ============================================================================
// Module      : json_feedback_receiver
// Description : 8N1 UART receiver feeding a small JSON parser that extracts
//               the signed integer values of keys "L" and "R" from frames of
//               the form {"L":<int>,"R":<int>}.
// Revision    : 1.0 - initial release
// ============================================================================
module json_feedback_receiver #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_in,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic [15:0] speed_left,
  output logic [15:0] speed_right,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] c_full = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] c_half = CNT_W'(BAUD_DIV / 2 - 1);

  localparam logic [7:0] c_lbrace = 8'h7B;
  localparam logic [7:0] c_rbrace = 8'h7D;
  localparam logic [7:0] c_quote  = 8'h22;
  localparam logic [7:0] c_colon  = 8'h3A;
  localparam logic [7:0] c_comma  = 8'h2C;
  localparam logic [7:0] c_minus  = 8'h2D;
  localparam logic [7:0] c_key_l  = 8'h4C;
  localparam logic [7:0] c_key_r  = 8'h52;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    P_IDLE  = 3'd0,
    P_Q1    = 3'd1,
    P_KEY   = 3'd2,
    P_Q2    = 3'd3,
    P_COLON = 3'd4,
    P_SIGN  = 3'd5,
    P_DIGIT = 3'd6
  } p_state_t;

  // ---------------------------------------------------------------- UART RX
  logic [1:0]       r_sync;
  logic             r_line_prev;
  logic             w_line;
  rx_state_t        r_rx_state, w_rx_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]       r_bit_idx, w_bit_next;
  logic [7:0]       r_shift, w_shift_next;
  logic [7:0]       r_rx_byte;
  logic             r_rx_valid;
  logic             r_stop_err;
  logic             w_byte_ok, w_stop_bad;

  assign w_line = r_sync[1];

  // Synchronizer, edge history and RX state register. The synchronizer
  // resets low so a line that is low when reset releases is never taken
  // as a start bit; the line has to be seen idle-high first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= 2'b00;
      r_line_prev <= 1'b0;
      r_rx_state  <= RX_IDLE;
    end else begin
      r_sync      <= {r_sync[0], uart_in};
      r_line_prev <= w_line;
      r_rx_state  <= w_rx_next;
    end
  end

  // RX next-state, bit sampling and end-of-byte strobes
  always_comb begin
    w_rx_next    = r_rx_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_byte_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_cnt_next = '0;
        if (r_line_prev && !w_line) w_rx_next = RX_START;
      end
      RX_START: begin
        if (r_cnt == c_half) begin
          w_cnt_next = '0;
          w_bit_next = 3'd0;
          w_rx_next  = w_line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == c_full) begin
          w_cnt_next   = '0;
          w_shift_next = {w_line, r_shift[7:1]};
          w_bit_next   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == c_full) begin
          w_cnt_next = '0;
          w_rx_next  = RX_IDLE;
          w_byte_ok  = w_line;
          w_stop_bad = !w_line;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // RX datapath: bit counter, shifter and the received-byte outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_rx_byte  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_bit_idx  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_rx_valid <= w_byte_ok;
      r_stop_err <= w_stop_bad;
      if (w_byte_ok) r_rx_byte <= r_shift;
    end
  end

  // ---------------------------------------------------------------- parser
  p_state_t    r_pstate, w_p_next;
  logic [7:0]  r_key, w_key_n;
  logic        r_neg, w_neg_n;
  logic [16:0] r_acc, w_acc_n;
  logic [2:0]  r_ndig, w_ndig_n;
  logic        r_seen_l, w_seen_l_n, r_seen_r, w_seen_r_n;
  logic [15:0] r_cand_l, w_cand_l_n, r_cand_r, w_cand_r_n;
  logic [15:0] r_speed_l, w_speed_l_n, r_speed_r, w_speed_r_n;
  logic        r_frame_valid, r_frame_error;
  logic        w_fv, w_perr;
  logic        w_is_ws, w_is_digit;
  logic [19:0] w_acc_calc;
  logic [15:0] w_value;

  assign w_is_ws    = (r_rx_byte == 8'h20) || (r_rx_byte == 8'h0D) || (r_rx_byte == 8'h0A);
  assign w_is_digit = (r_rx_byte >= 8'h30) && (r_rx_byte <= 8'h39);
  // Computed wide so a value beyond 32767 is caught before truncation.
  assign w_acc_calc = {3'd0, r_acc} * 20'd10 + {16'd0, r_rx_byte[3:0]};
  assign w_value    = r_neg ? (16'd0 - r_acc[15:0]) : r_acc[15:0];

  // Parser next-state, value commit and frame result strobes
  always_comb begin
    w_p_next    = r_pstate;
    w_key_n     = r_key;
    w_neg_n     = r_neg;
    w_acc_n     = r_acc;
    w_ndig_n    = r_ndig;
    w_seen_l_n  = r_seen_l;
    w_seen_r_n  = r_seen_r;
    w_cand_l_n  = r_cand_l;
    w_cand_r_n  = r_cand_r;
    w_speed_l_n = r_speed_l;
    w_speed_r_n = r_speed_r;
    w_fv        = 1'b0;
    w_perr      = 1'b0;
    if (r_stop_err) begin
      // A corrupted byte makes the rest of the frame untrustworthy.
      w_p_next = P_IDLE;
    end else if (r_rx_valid) begin
      if (r_rx_byte == c_lbrace) begin
        // Opening brace always (re)starts a frame, even mid-frame.
        w_p_next   = P_Q1;
        w_seen_l_n = 1'b0;
        w_seen_r_n = 1'b0;
        w_cand_l_n = 16'h0000;
        w_cand_r_n = 16'h0000;
        w_neg_n    = 1'b0;
        w_acc_n    = 17'd0;
        w_ndig_n   = 3'd0;
      end else begin
        case (r_pstate)
          P_IDLE: ;
          P_Q1: begin
            if (r_rx_byte == c_quote) w_p_next = P_KEY;
            else if (!w_is_ws)        w_perr   = 1'b1;
          end
          P_KEY: begin
            w_key_n  = r_rx_byte;
            w_p_next = P_Q2;
          end
          P_Q2: begin
            if (r_rx_byte == c_quote) w_p_next = P_COLON;
            else if (!w_is_ws)        w_perr   = 1'b1;
          end
          P_COLON: begin
            if (r_rx_byte == c_colon) begin
              w_p_next = P_SIGN;
              w_neg_n  = 1'b0;
              w_acc_n  = 17'd0;
              w_ndig_n = 3'd0;
            end else if (!w_is_ws) begin
              w_perr = 1'b1;
            end
          end
          P_SIGN: begin
            if (r_rx_byte == c_minus) begin
              w_neg_n  = 1'b1;
              w_p_next = P_DIGIT;
            end else if (w_is_digit) begin
              w_acc_n  = {13'd0, r_rx_byte[3:0]};
              w_ndig_n = 3'd1;
              w_p_next = P_DIGIT;
            end else if (!w_is_ws) begin
              w_perr = 1'b1;
            end
          end
          P_DIGIT: begin
            if (w_is_digit) begin
              if ((r_ndig >= 3'd5) || (w_acc_calc > 20'd32767)) begin
                w_perr = 1'b1;
              end else begin
                w_acc_n  = w_acc_calc[16:0];
                w_ndig_n = r_ndig + 3'd1;
              end
            end else if ((r_rx_byte == c_comma) || (r_rx_byte == c_rbrace)) begin
              if (r_ndig == 3'd0) begin
                w_perr = 1'b1;
              end else begin
                if (r_key == c_key_l) begin
                  w_cand_l_n = w_value;
                  w_seen_l_n = 1'b1;
                end
                if (r_key == c_key_r) begin
                  w_cand_r_n = w_value;
                  w_seen_r_n = 1'b1;
                end
                if (r_rx_byte == c_comma) begin
                  w_p_next = P_Q1;
                end else if (w_seen_l_n && w_seen_r_n) begin
                  w_speed_l_n = w_cand_l_n;
                  w_speed_r_n = w_cand_r_n;
                  w_fv        = 1'b1;
                  w_p_next    = P_IDLE;
                end else begin
                  w_perr = 1'b1;
                end
              end
            end else if (!(w_is_ws && (r_ndig == 3'd0))) begin
              // Whitespace splitting a digit run is not accepted.
              w_perr = 1'b1;
            end
          end
          default: w_p_next = P_IDLE;
        endcase
        if (w_perr) w_p_next = P_IDLE;
      end
    end
  end

  // Parser state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pstate      <= P_IDLE;
      r_key         <= 8'h00;
      r_neg         <= 1'b0;
      r_acc         <= 17'd0;
      r_ndig        <= 3'd0;
      r_seen_l      <= 1'b0;
      r_seen_r      <= 1'b0;
      r_cand_l      <= 16'h0000;
      r_cand_r      <= 16'h0000;
      r_speed_l     <= 16'h0000;
      r_speed_r     <= 16'h0000;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_pstate      <= w_p_next;
      r_key         <= w_key_n;
      r_neg         <= w_neg_n;
      r_acc         <= w_acc_n;
      r_ndig        <= w_ndig_n;
      r_seen_l      <= w_seen_l_n;
      r_seen_r      <= w_seen_r_n;
      r_cand_l      <= w_cand_l_n;
      r_cand_r      <= w_cand_r_n;
      r_speed_l     <= w_speed_l_n;
      r_speed_r     <= w_speed_r_n;
      r_frame_valid <= w_fv;
      // Stop-bit errors and parse errors come from distinct bytes, and a
      // parse error never coincides with a frame commit.
      r_frame_error <= w_perr | r_stop_err;
    end
  end

  assign rx_byte     = r_rx_byte;
  assign rx_valid    = r_rx_valid;
  assign speed_left  = r_speed_l;
  assign speed_right = r_speed_r;
  assign frame_valid = r_frame_valid;
  assign frame_error = r_frame_error;
  assign busy        = (r_pstate != P_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_json_feedback_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_json_feedback_receiver
// Description : Directed self-checking bench for json_feedback_receiver with
//               a byte scoreboard and a frame-result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_json_feedback_receiver;

  localparam int CLK_FREQ = 1_843_200;
  localparam int BAUD     = 115200;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_in = 1'b1;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [15:0] speed_left;
  logic [15:0] speed_right;
  logic        frame_valid;
  logic        frame_error;
  logic        busy;

  typedef struct packed {
    logic [1:0]  kind;   // 1 = frame_valid, 2 = frame_error
    logic [15:0] l;
    logic [15:0] r;
  } ev_t;

  logic [7:0] byte_q[$];
  ev_t        ev_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rxv = -10;

  json_feedback_receiver #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_in     (uart_in),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .speed_left  (speed_left),
    .speed_right (speed_right),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [15:0] l, input logic [15:0] r);
    ev_t e;
    e.kind = kind;
    e.l    = l;
    e.r    = r;
    ev_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) byte_q.push_back(b);
    uart_in = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_in = stop_ok;
    repeat (DIV) @(negedge clk);
    uart_in = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  // Output monitor: pops the scoreboards whenever the DUT reports something
  always @(negedge clk) begin
    ev_t        e;
    logic [7:0] eb;
    cyc = cyc + 1;
    if (!rst) begin
      if (rx_valid) begin
        check("rx_valid_expected", 32'(byte_q.size() > 0), 32'd1);
        if (byte_q.size() > 0) begin
          eb = byte_q.pop_front();
          check("rx_byte", 32'(rx_byte), 32'(eb));
        end
        last_rxv = cyc;
      end
      if (frame_valid) begin
        check("fv_fe_exclusive", 32'(frame_error), 32'd0);
        check("fv_latency", 32'(cyc - last_rxv), 32'd1);
        check("fv_expected", 32'(ev_q.size() > 0), 32'd1);
        if (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          check("fv_kind", 32'(e.kind), 32'd1);
          check("fv_speed_left", 32'(speed_left), 32'(e.l));
          check("fv_speed_right", 32'(speed_right), 32'(e.r));
        end
      end
      if (frame_error) begin
        check("fe_expected", 32'(ev_q.size() > 0), 32'd1);
        if (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          check("fe_kind", 32'(e.kind), 32'd2);
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    uart_in = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rx_byte",     32'(rx_byte),     32'h00);
    check("rst_rx_valid",    32'(rx_valid),    32'd0);
    check("rst_speed_left",  32'(speed_left),  32'd0);
    check("rst_speed_right", 32'(speed_right), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);

    // Single byte outside any frame
    send_byte(8'h5A, 1'b1);
    check("byte_5a", 32'(rx_byte), 32'h5A);
    check("byte_5a_busy", 32'(busy), 32'd0);

    // Good frame with a negative value
    push_ev(2'd1, 16'd120, 16'hFFD3);
    send_str("{");
    check("busy_in_frame", 32'(busy), 32'd1);
    send_str("\"L\":120,\"R\":-45}");
    check("f1_left",  32'(speed_left),  32'd120);
    check("f1_right", 32'(speed_right), 32'hFFD3);
    check("f1_busy",  32'(busy),        32'd0);

    // Missing L key
    push_ev(2'd2, 16'd0, 16'd0);
    send_str("{\"T\":1001,\"R\":7}");
    check("f2_left",  32'(speed_left),  32'd120);
    check("f2_right", 32'(speed_right), 32'hFFD3);

    // Overflow on the fifth digit; the rest of the frame is ignored
    push_ev(2'd2, 16'd0, 16'd0);
    send_str("{\"L\":4000");
    check("f3_busy_before", 32'(busy), 32'd1);
    send_str("0");
    check("f3_busy_after", 32'(busy), 32'd0);
    send_str(",\"R\":1}");
    check("f3_left",  32'(speed_left),  32'd120);
    check("f3_right", 32'(speed_right), 32'hFFD3);

    // Stop bit low inside a frame
    send_str("{\"");
    check("f4_busy", 32'(busy), 32'd1);
    push_ev(2'd2, 16'd0, 16'd0);
    send_byte(8'h41, 1'b0);
    check("f4_busy_after", 32'(busy), 32'd0);
    check("f4_rx_byte_kept", 32'(rx_byte), 32'h22);

    // Restart mid-frame
    push_ev(2'd1, 16'd6, 16'd2);
    send_str("{\"L\":5,{\"L\":6,\"R\":2}");
    check("f5_left",  32'(speed_left),  32'd6);
    check("f5_right", 32'(speed_right), 32'd2);

    // Whitespace between tokens and a duplicate key
    push_ev(2'd1, 16'hFFF9, 16'd300);
    send_str("{ \"R\" : 300,\r\n\"L\":3,\"L\":-7}");
    check("f6_left",  32'(speed_left),  32'hFFF9);
    check("f6_right", 32'(speed_right), 32'd300);

    // Largest magnitudes accepted
    push_ev(2'd1, 16'h7FFF, 16'h8001);
    send_str("{\"L\":32767,\"R\":-32767}");
    check("f7_left",  32'(speed_left),  32'h7FFF);
    check("f7_right", 32'(speed_right), 32'h8001);

    // Reset in the middle of a frame and of a byte
    send_str("{\"L\":9");
    uart_in = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rst     = 1'b1;
    uart_in = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_rx_byte", 32'(rx_byte),     32'h00);
    check("mid_rst_left",    32'(speed_left),  32'd0);
    check("mid_rst_right",   32'(speed_right), 32'd0);
    check("mid_rst_busy",    32'(busy),        32'd0);
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);

    push_ev(2'd1, 16'd1, 16'd1);
    send_str("{\"L\":1,\"R\":1}");
    check("f8_left",  32'(speed_left),  32'd1);
    check("f8_right", 32'(speed_right), 32'd1);

    repeat (4 * DIV) @(negedge clk);
    check("bytes_drained",  32'(byte_q.size()), 32'd0);
    check("events_drained", 32'(ev_q.size()),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
